// File: rtl/shell_cmd_ctrl.sv
// Shell command sequencer: collects an ASCII line from the UART receiver,
// parses an r/w/g command with hex arguments, performs one RAM access or a
// run request, and streams the reply (hex digits or status) to the UART TX.
module shell_cmd_ctrl #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int LINE_MAX = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              rx_dv,
    input  logic [7:0]        rx_byte,
    output logic              tx_valid,
    output logic [7:0]        tx_byte,
    input  logic              tx_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              go,
    output logic [ADDR_W-1:0] go_addr,
    output logic              busy
);

    localparam int CNT_W = $clog2(LINE_MAX + 1);

    localparam logic [7:0] CH_SP  = 8'h20;
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_CR  = 8'h0D;
    localparam logic [7:0] CH_Q   = 8'h3F;
    localparam logic [7:0] CH_R   = 8'h72;
    localparam logic [7:0] CH_W   = 8'h77;
    localparam logic [7:0] CH_G   = 8'h67;

    typedef enum logic [2:0] {
        S_COLLECT,
        S_EXEC,
        S_RD_WAIT,
        S_TX_HEX,
        S_TX_ERR,
        S_TX_CR,
        S_TX_LF
    } state_t;

    state_t r_state;
    state_t w_next;

    // Parser state; arguments are kept 16 bits wide (4 hex digits) and
    // truncated to the port widths where they leave the block.
    logic [7:0]        r_cmd;
    logic [1:0]        r_field;
    logic              r_have;
    logic [1:0]        r_argc;
    logic              r_err;
    logic [CNT_W-1:0]  r_cnt;
    logic [15:0]       r_arg1;
    logic [15:0]       r_arg2;

    logic [15:0]       r_rdata;
    logic [1:0]        r_nib;
    logic [ADDR_W-1:0] r_go_addr;

    logic [4:0]        w_hex;
    logic              w_rx;
    logic              w_rx_char;
    logic              w_line_end;
    logic              w_argc_ok;
    logic              w_cmd_ok;
    logic [3:0]        w_nibble;
    logic [ADDR_W-1:0] w_go_target;

    // Hex digit decode: returns {valid, value}.
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        logic [4:0] v;
        v = 5'd0;
        if (c >= 8'h30 && c <= 8'h39)      v = {1'b1, c[3:0]};
        else if (c >= 8'h61 && c <= 8'h66) v = {1'b1, c[3:0] + 4'd9};
        else if (c >= 8'h41 && c <= 8'h46) v = {1'b1, c[3:0] + 4'd9};
        return v;
    endfunction

    // Nibble to uppercase ASCII hex character.
    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign w_hex       = hex_decode(rx_byte);
    assign w_rx        = rx_dv && (r_state == S_COLLECT);
    assign w_rx_char   = w_rx && (rx_byte != CH_LF) && (rx_byte != CH_CR);
    assign w_line_end  = w_rx && (rx_byte == CH_CR) && (r_cnt != '0);
    assign w_argc_ok   = ((r_cmd == CH_R) && (r_argc == 2'd1)) ||
                         ((r_cmd == CH_W) && (r_argc == 2'd2)) ||
                         ((r_cmd == CH_G) && (r_argc <= 2'd1));
    assign w_cmd_ok    = !r_err && w_argc_ok;
    assign w_nibble    = 4'(r_rdata >> {~r_nib, 2'b00});
    assign w_go_target = (r_argc == 2'd1) ? r_arg1[ADDR_W-1:0] : '0;

    assign mem_addr  = r_arg1[ADDR_W-1:0];
    assign mem_wdata = r_arg2[DATA_W-1:0];
    assign busy      = (r_state != S_COLLECT);

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= S_COLLECT;
        else     r_state <= w_next;
    end

    // Next state, strobes and reply byte selection.
    always_comb begin
        w_next   = r_state;
        mem_we   = 1'b0;
        mem_re   = 1'b0;
        go       = 1'b0;
        go_addr  = r_go_addr;
        tx_valid = 1'b0;
        tx_byte  = 8'h00;
        case (r_state)
            S_COLLECT: begin
                if (w_line_end) w_next = S_EXEC;
            end
            S_EXEC: begin
                if (!w_cmd_ok) begin
                    w_next = S_TX_ERR;
                end else if (r_cmd == CH_W) begin
                    mem_we = 1'b1;
                    w_next = S_TX_CR;
                end else if (r_cmd == CH_R) begin
                    mem_re = 1'b1;
                    w_next = S_RD_WAIT;
                end else begin
                    go      = 1'b1;
                    go_addr = w_go_target;
                    w_next  = S_TX_CR;
                end
            end
            S_RD_WAIT: w_next = S_TX_HEX;
            S_TX_HEX: begin
                tx_valid = 1'b1;
                tx_byte  = hex_ascii(w_nibble);
                if (tx_ready && (r_nib == 2'd3)) w_next = S_TX_CR;
            end
            S_TX_ERR: begin
                tx_valid = 1'b1;
                tx_byte  = CH_Q;
                if (tx_ready) w_next = S_TX_CR;
            end
            S_TX_CR: begin
                tx_valid = 1'b1;
                tx_byte  = CH_CR;
                if (tx_ready) w_next = S_TX_LF;
            end
            S_TX_LF: begin
                tx_valid = 1'b1;
                tx_byte  = CH_LF;
                if (tx_ready) w_next = S_COLLECT;
            end
            default: w_next = S_COLLECT;
        endcase
    end

    // Line parser; cleared once the command has been dispatched.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cmd   <= '0;
            r_field <= '0;
            r_have  <= 1'b0;
            r_argc  <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
            r_arg1  <= '0;
            r_arg2  <= '0;
        end else if (r_state == S_EXEC) begin
            r_cmd   <= '0;
            r_field <= '0;
            r_have  <= 1'b0;
            r_argc  <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
            r_arg1  <= '0;
            r_arg2  <= '0;
        end else if (w_rx_char) begin
            if (r_cnt == CNT_W'(LINE_MAX)) r_err <= 1'b1;
            else                           r_cnt <= r_cnt + CNT_W'(1);
            if (rx_byte == CH_SP) begin
                // Only a space that closes a non-empty field moves to the next one.
                if (r_have) begin
                    r_have <= 1'b0;
                    if (r_field != 2'd3) r_field <= r_field + 2'd1;
                end
            end else begin
                r_have <= 1'b1;
                case (r_field)
                    2'd0: begin
                        if (r_have) begin
                            r_err <= 1'b1;
                        end else begin
                            r_cmd <= rx_byte;
                            if ((rx_byte != CH_R) && (rx_byte != CH_W) && (rx_byte != CH_G))
                                r_err <= 1'b1;
                        end
                    end
                    2'd1, 2'd2: begin
                        if (!r_have) r_argc <= r_argc + 2'd1;
                        if (!w_hex[4])           r_err  <= 1'b1;
                        else if (r_field == 2'd1) r_arg1 <= {r_arg1[11:0], w_hex[3:0]};
                        else                      r_arg2 <= {r_arg2[11:0], w_hex[3:0]};
                    end
                    default: r_err <= 1'b1;
                endcase
            end
        end
    end

    // Read data capture, one cycle after the read strobe.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                        r_rdata <= '0;
        else if (r_state == S_RD_WAIT)  r_rdata <= 16'(mem_rdata);
    end

    // Hex digit index, advanced on each accepted digit; wraps back to 0.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                                r_nib <= '0;
        else if ((r_state == S_TX_HEX) && tx_ready) r_nib <= r_nib + 2'd1;
    end

    // Run address is held after the go pulse until the next one.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)     r_go_addr <= '0;
        else if (go) r_go_addr <= w_go_target;
    end

endmodule

// File: tb/tb_shell_cmd_ctrl.sv
// Self-checking bench for shell_cmd_ctrl: directed lines plus random lines
// compared against a token-level reference parser and a RAM model.
module tb_shell_cmd_ctrl;

    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 16;
    localparam int LINE_MAX = 16;

    localparam int K_NONE = 0;
    localparam int K_ERR  = 1;
    localparam int K_WR   = 2;
    localparam int K_RD   = 3;
    localparam int K_GO   = 4;

    localparam logic [1:0] EV_W = 2'd1;
    localparam logic [1:0] EV_R = 2'd2;
    localparam logic [1:0] EV_G = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] addr;
        logic [15:0] data;
    } ev_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        rx_dv = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        tx_valid;
    logic [7:0]  tx_byte;
    logic        tx_ready = 1'b0;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [15:0] mem_rdata = 16'h0000;
    logic        go;
    logic [15:0] go_addr;
    logic        busy;

    shell_cmd_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_MAX(LINE_MAX)
    ) dut (
        .CLK(CLK), .RST(RST),
        .rx_dv(rx_dv), .rx_byte(rx_byte),
        .tx_valid(tx_valid), .tx_byte(tx_byte), .tx_ready(tx_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
        .go(go), .go_addr(go_addr), .busy(busy)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    logic [15:0] ram     [0:65535];
    logic [15:0] ref_ram [0:65535];
    logic [7:0]  tx_q[$];
    ev_t         ev_q[$];
    int          rdy_mode = 1;

    // tx_ready pattern: 0 random, 1 always ready, 2 stalled.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            case (rdy_mode)
                0:       tx_ready = ($urandom_range(0, 3) != 0);
                1:       tx_ready = 1'b1;
                default: tx_ready = 1'b0;
            endcase
        end
    end

    logic        pend = 1'b0;
    logic [7:0]  pend_b = 8'h00;
    logic        rd_pend = 1'b0;
    logic [15:0] rd_addr = 16'h0000;

    // Monitor and RAM responder, sampled on the falling edge.
    always @(negedge CLK) begin
        if (RST) begin
            pend    = 1'b0;
            rd_pend = 1'b0;
        end else begin
            if (pend) begin
                check("tx_hold_valid", tx_valid, 1);
                check("tx_hold_byte", tx_byte, pend_b);
            end
            pend   = tx_valid && !tx_ready;
            pend_b = tx_byte;
            if (tx_valid && tx_ready) tx_q.push_back(tx_byte);
            if (mem_we || mem_re || go) begin
                check("strobe_excl", 32'(mem_we) + 32'(mem_re) + 32'(go), 1);
                check("strobe_busy", busy, 1);
            end
            if (mem_we) begin
                ev_q.push_back(ev_t'{EV_W, mem_addr, mem_wdata});
                ram[mem_addr] = mem_wdata;
            end
            if (mem_re) ev_q.push_back(ev_t'{EV_R, mem_addr, 16'h0000});
            if (go)     ev_q.push_back(ev_t'{EV_G, go_addr, 16'h0000});
            // Read data is valid only during the cycle after the strobe.
            if (rd_pend) begin
                mem_rdata = ram[rd_addr];
                rd_pend   = 1'b0;
            end else begin
                mem_rdata = 16'($urandom);
            end
            if (mem_re) begin
                rd_pend = 1'b1;
                rd_addr = mem_addr;
            end
        end
    end

    function automatic bit hex_val(input byte c, output logic [3:0] v);
        int ci;
        ci = int'(c);
        v  = 4'h0;
        if (ci >= 48 && ci <= 57)  begin v = 4'(ci - 48); return 1'b1; end
        if (ci >= 97 && ci <= 102) begin v = 4'(ci - 87); return 1'b1; end
        if (ci >= 65 && ci <= 70)  begin v = 4'(ci - 55); return 1'b1; end
        return 1'b0;
    endfunction

    function automatic logic [7:0] hexch(input logic [3:0] n);
        return (n < 4'd10) ? 8'(48 + int'(n)) : 8'(55 + int'(n));
    endfunction

    // Reference parser: drop LFs, split on spaces, validate tokens.
    function automatic void model(input string s, output int kind,
                                  output logic [15:0] a, output logic [15:0] d);
        string       t;
        string       cur;
        string       tk;
        string       toks[$];
        logic [15:0] vals[2];
        logic [3:0]  nv;
        longint      acc;
        int          nargs;
        kind = K_NONE;
        a = 16'h0;
        d = 16'h0;
        t = "";
        cur = "";
        for (int i = 0; i < s.len(); i++)
            if (s[i] != 8'h0A) t = {t, s.substr(i, i)};
        if (t.len() == 0) return;
        kind = K_ERR;
        if (t.len() > LINE_MAX) return;
        for (int i = 0; i < t.len(); i++) begin
            if (t[i] == 8'h20) begin
                if (cur.len() > 0) toks.push_back(cur);
                cur = "";
            end else begin
                cur = {cur, t.substr(i, i)};
            end
        end
        if (cur.len() > 0) toks.push_back(cur);
        if (toks.size() == 0 || toks.size() > 3) return;
        if (toks[0].len() != 1) return;
        vals[0] = 16'h0;
        vals[1] = 16'h0;
        for (int k = 1; k < toks.size(); k++) begin
            tk  = toks[k];
            acc = 0;
            for (int i = 0; i < tk.len(); i++) begin
                if (!hex_val(tk[i], nv)) return;
                acc = (acc * 16 + longint'(nv)) % 65536;
            end
            vals[k-1] = 16'(acc);
        end
        nargs = toks.size() - 1;
        if (toks[0] == "r" && nargs == 1) begin
            kind = K_RD; a = vals[0];
        end else if (toks[0] == "w" && nargs == 2) begin
            kind = K_WR; a = vals[0]; d = vals[1];
        end else if (toks[0] == "g" && nargs <= 1) begin
            kind = K_GO; a = (nargs == 1) ? vals[0] : 16'h0;
        end
    endfunction

    task automatic check_reply(input string s);
        int          kind;
        logic [15:0] a;
        logic [15:0] d;
        logic [15:0] rv;
        logic [7:0]  exp_tx[$];
        logic [1:0]  exp_kind;
        int          exp_ev;
        model(s, kind, a, d);
        if (kind == K_ERR) begin
            exp_tx.push_back(8'h3F);
        end else if (kind == K_RD) begin
            rv = ref_ram[a];
            for (int i = 3; i >= 0; i--) exp_tx.push_back(hexch(4'(rv >> (4 * i))));
        end
        if (kind != K_NONE) begin
            exp_tx.push_back(8'h0D);
            exp_tx.push_back(8'h0A);
        end
        check("tx_count", tx_q.size(), exp_tx.size());
        for (int i = 0; i < exp_tx.size() && i < tx_q.size(); i++)
            check("tx_byte", tx_q[i], exp_tx[i]);
        exp_ev   = (kind >= K_WR) ? 1 : 0;
        exp_kind = (kind == K_WR) ? EV_W : (kind == K_RD) ? EV_R : EV_G;
        check("ev_count", ev_q.size(), exp_ev);
        if (exp_ev == 1 && ev_q.size() == 1) begin
            check("ev_kind", ev_q[0].kind, exp_kind);
            check("ev_addr", ev_q[0].addr, a);
            if (kind == K_WR) check("ev_wdata", ev_q[0].data, d);
        end
        if (kind == K_WR) ref_ram[a] = d;
        if (kind == K_GO) check("go_addr_hold", go_addr, a);
        tx_q.delete();
        ev_q.delete();
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] c);
        rx_byte = c;
        rx_dv   = 1'b1;
        tick();
        rx_dv   = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        if (busy) check("idle_timeout", 1, 0);
    endtask

    task automatic wait_tx_valid(input int budget);
        int n;
        n = 0;
        while (!tx_valid && n < budget) begin
            tick();
            n++;
        end
        check("tx_valid_seen", tx_valid, 1);
    endtask

    task automatic run_line(input string s);
        send_str(s);
        send_byte(8'h0D);
        tick();
        wait_idle(5000);
        tick();
        check_reply(s);
    endtask

    function automatic string gen_line();
        string s;
        string hx;
        int    sel;
        int    nargs;
        int    len;
        hx = "0123456789abcdefABCDEF";
        s  = ($urandom_range(0, 7) == 0) ? " " : "";
        sel = $urandom_range(0, 9);
        case (sel)
            0, 1, 2: s = {s, "r"};
            3, 4, 5: s = {s, "w"};
            6, 7:    s = {s, "g"};
            8:       s = {s, "q"};
            default: s = {s, "rw"};
        endcase
        nargs = (sel <= 2) ? 1 : (sel <= 5) ? 2 : $urandom_range(0, 1);
        if ($urandom_range(0, 4) == 0) nargs = $urandom_range(0, 3);
        for (int k = 0; k < nargs; k++) begin
            s = {s, " "};
            if ($urandom_range(0, 5) == 0) s = {s, " "};
            len = $urandom_range(1, 5);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 40) == 0) s = {s, "G"};
                else s = $sformatf("%s%c", s, hx[$urandom_range(0, 21)]);
                if ($urandom_range(0, 50) == 0) s = {s, "\n"};
            end
        end
        if ($urandom_range(0, 6) == 0) s = {s, " "};
        return s;
    endfunction

    initial begin
        for (int i = 0; i < 65536; i++) begin
            ram[i]     = 16'($urandom);
            ref_ram[i] = ram[i];
        end

        // Reset state.
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_byte", tx_byte, 0);
        check("rst_busy", busy, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_re", mem_re, 0);
        check("rst_go", go, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_go_addr", go_addr, 0);
        tick();
        RST = 1'b0;
        rdy_mode = 1;
        tick();

        // Basic write / read / go.
        run_line("w 0011 1111");
        run_line("r 11");
        run_line("g ");
        run_line("g 1A2b");

        // Malformed lines, including one character past the line limit.
        run_line("x 12");
        run_line("r");
        run_line("r 12 34");
        run_line("w 1G 2");
        run_line("w     1111 2222  ");
        run_line("w    1111 2222  ");

        // Parsing edges.
        run_line("r 12345");
        run_line("");
        run_line("r  00\n10");

        // Backpressure with rx bytes arriving while busy.
        run_line("w 0200 00ff");
        rdy_mode = 2;
        tick();
        send_str("r 200");
        send_byte(8'h0D);
        wait_tx_valid(50);
        send_str("w 5 5");
        send_byte(8'h0D);
        repeat (44) tick();
        check("bp_valid", tx_valid, 1);
        check("bp_byte", tx_byte, 8'h30);
        check("bp_busy", busy, 1);
        check("bp_no_tx", tx_q.size(), 0);
        rdy_mode = 1;
        wait_idle(200);
        tick();
        check_reply("r 200");
        run_line("r 5");

        // Reset in the middle of a hex reply.
        rdy_mode = 2;
        tick();
        send_str("r 11");
        send_byte(8'h0D);
        wait_tx_valid(50);
        check("rm_first_digit", tx_byte, 8'h31);
        RST = 1'b1;
        @(negedge CLK);
        check("rm_tx_valid", tx_valid, 0);
        check("rm_busy", busy, 0);
        tick();
        RST = 1'b0;
        tx_q.delete();
        ev_q.delete();
        rdy_mode = 1;
        repeat (20) tick();
        check("rm_no_tx", tx_q.size(), 0);
        check("rm_no_ev", ev_q.size(), 0);
        run_line("r 11");

        // Random lines with random tx_ready.
        rdy_mode = 0;
        for (int n = 0; n < 200; n++) run_line(gen_line());

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
